// File: rtl/conv_pkg.sv
// Shared state encoding and arithmetic helpers for conv_engine_param.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        DRAIN1 = 3'd2,
        DRAIN2 = 3'd3,
        OUT    = 3'd4
    } conv_state_e;

    localparam int SAT_W = 64;

    function automatic int kk(input int ksize);
        return ksize * ksize;
    endfunction

    // Floor-shift a wide accumulator by frac_bits, then clamp to a signed data_width range.
    function automatic logic signed [SAT_W-1:0] shift_sat(input logic signed [SAT_W-1:0] acc,
                                                          input int frac_bits,
                                                          input int data_width);
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh = acc >>> frac_bits;
        hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_width - 1));
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end else begin
            return sh;
        end
    endfunction

endpackage

// File: rtl/conv_sat_relu.sv
// Accumulator to DATA_WIDTH result: floor shift, saturation and, with CONV_RELU_EN defined, ReLU.
module conv_sat_relu
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH  = 40,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic        [DATA_WIDTH-1:0] data_o
);

    logic signed [SAT_W-1:0] acc_ext_s;
    logic signed [SAT_W-1:0] sat_s;
    logic                    sat_unused_s;

    // Sign-extend, shift/saturate, then optionally clamp negatives to zero
    always_comb begin
        acc_ext_s    = {{(SAT_W-ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
        sat_s        = shift_sat(acc_ext_s, FRAC_BITS, DATA_WIDTH);
        sat_unused_s = ^sat_s[SAT_W-1:DATA_WIDTH];
`ifdef CONV_RELU_EN
        if (sat_s[SAT_W-1]) begin
            data_o = {DATA_WIDTH{1'b0}};
        end else begin
            data_o = sat_s[DATA_WIDTH-1:0];
        end
`else
        data_o = sat_s[DATA_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/conv_engine_param.sv
// K x K valid-convolution engine over an external feature RAM; FSM, weight file and MAC.
// Optional ReLU on results is enabled by defining CONV_RELU_EN.
module conv_engine_param
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH            = 16,
    parameter int FRAC_BITS             = 8,
    parameter int IN_FEATURE_ADDR_WIDTH = 11,
    parameter int IMG_W                 = 8,
    parameter int IMG_H                 = 8,
    parameter int KSIZE                 = 3,
    parameter int ACC_WIDTH             = 40,
    localparam int WT_AW                = (kk(KSIZE) > 1) ? $clog2(kk(KSIZE)) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             start,
    input  logic                             wt_wren,
    input  logic [WT_AW-1:0]                 wt_addr,
    input  logic [DATA_WIDTH-1:0]            wt_data,
    output logic [IN_FEATURE_ADDR_WIDTH-1:0] in_feature_addr,
    output logic                             in_feature_rden,
    input  logic [DATA_WIDTH-1:0]            in_feature_q,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH-1:0]            finalresult
);

    localparam int KK = kk(KSIZE);
    localparam int AW = IN_FEATURE_ADDR_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int OW = IMG_W - KSIZE + 1;
    localparam int OH = IMG_H - KSIZE + 1;
    localparam logic [AW-1:0]    ZERO    = {AW{1'b0}};
    localparam logic [AW-1:0]    ONE     = AW'(1);
    localparam logic [AW-1:0]    K_LAST  = AW'(KSIZE - 1);
    localparam logic [AW-1:0]    OW_LAST = AW'(OW - 1);
    localparam logic [AW-1:0]    OH_LAST = AW'(OH - 1);
    localparam logic [WT_AW-1:0] WZERO   = {WT_AW{1'b0}};
    localparam logic [WT_AW-1:0] WONE    = WT_AW'(1);

    conv_state_e state_q, state_d;
    logic [AW-1:0]    kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
    logic [WT_AW-1:0] kidx_q, kidx_d;
    logic             done_q, done_d;
    logic             pix_end_s;

    logic [DATA_WIDTH-1:0] wt_q [KK];

    logic                  rd_vld_q;
    logic [WT_AW-1:0]      rd_idx_q;
    logic                  cap_vld_q, bk_vld_q;
    logic [WT_AW-1:0]      cap_idx_q, bk_idx_q;
    logic [DATA_WIDTH-1:0] cap_data_q, bk_data_q;

    logic                        use_bk_s, use_cap_s;
    logic [DATA_WIDTH-1:0]       mac_data_s;
    logic [WT_AW-1:0]            mac_idx_s;
    logic signed [PW-1:0]        prod_s;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]       sat_data_s;
    logic [DATA_WIDTH-1:0]       finalresult_q;

    // Next-state, window/pixel counters and pending done pulse
    always_comb begin
        state_d   = state_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        kidx_d    = kidx_q;
        done_d    = done_q & ~enable;
        pix_end_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && start) begin
                    state_d = READ;
                    kx_d    = ZERO;
                    ky_d    = ZERO;
                    ox_d    = ZERO;
                    oy_d    = ZERO;
                    kidx_d  = WZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (enable) begin
                    if (kx_q == K_LAST) begin
                        kx_d = ZERO;
                        if (ky_q == K_LAST) begin
                            ky_d    = ZERO;
                            kidx_d  = WZERO;
                            state_d = DRAIN1;
                        end else begin
                            ky_d   = ky_q + ONE;
                            kidx_d = kidx_q + WONE;
                        end
                    end else begin
                        kx_d   = kx_q + ONE;
                        kidx_d = kidx_q + WONE;
                    end
                end else begin
                    state_d = READ;
                end
            end
            DRAIN1: begin
                if (enable) begin
                    state_d = DRAIN2;
                end else begin
                    state_d = DRAIN1;
                end
            end
            DRAIN2: begin
                if (enable) begin
                    state_d = OUT;
                end else begin
                    state_d = DRAIN2;
                end
            end
            OUT: begin
                if (enable) begin
                    pix_end_s = 1'b1;
                    if ((ox_q == OW_LAST) && (oy_q == OH_LAST)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        ox_d    = ZERO;
                        oy_d    = ZERO;
                    end else if (ox_q == OW_LAST) begin
                        state_d = READ;
                        ox_d    = ZERO;
                        oy_d    = oy_q + ONE;
                    end else begin
                        state_d = READ;
                        ox_d    = ox_q + ONE;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Backlog slot is drained first; it only fills when a read lands during a stall
    always_comb begin
        use_bk_s  = enable & bk_vld_q;
        use_cap_s = enable & ~bk_vld_q & cap_vld_q;
        if (bk_vld_q) begin
            mac_data_s = bk_data_q;
            mac_idx_s  = bk_idx_q;
        end else begin
            mac_data_s = cap_data_q;
            mac_idx_s  = cap_idx_q;
        end
        prod_s = $signed(mac_data_s) * $signed(wt_q[mac_idx_s]);
        if (pix_end_s) begin
            acc_d = {ACC_WIDTH{1'b0}};
        end else if (use_bk_s || use_cap_s) begin
            acc_d = acc_q + {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s};
        end else begin
            acc_d = acc_q;
        end
    end

    // Read port and result strobes
    always_comb begin
        in_feature_rden = (state_q == READ) & enable;
        if (in_feature_rden) begin
            in_feature_addr = (oy_q + ky_q) * AW'(IMG_W) + ox_q + kx_q;
        end else begin
            in_feature_addr = ZERO;
        end
        out_valid = (state_q == OUT) & enable;
        if (out_valid) begin
            out_data = sat_data_s;
        end else begin
            out_data = {DATA_WIDTH{1'b0}};
        end
        done        = done_q & enable;
        busy        = (state_q != IDLE);
        finalresult = finalresult_q;
    end

    conv_sat_relu #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .acc_i (acc_q),
        .data_o(sat_data_s)
    );

    // Control state, accumulator and last-result register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            kx_q          <= ZERO;
            ky_q          <= ZERO;
            ox_q          <= ZERO;
            oy_q          <= ZERO;
            kidx_q        <= WZERO;
            done_q        <= 1'b0;
            acc_q         <= {ACC_WIDTH{1'b0}};
            finalresult_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            kidx_q  <= kidx_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            if (pix_end_s) begin
                finalresult_q <= sat_data_s;
            end
        end
    end

    // Read-landing capture; runs regardless of enable so no in-flight data is lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= WZERO;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= WZERO;
            cap_data_q <= {DATA_WIDTH{1'b0}};
            bk_vld_q   <= 1'b0;
            bk_idx_q   <= WZERO;
            bk_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_vld_q <= in_feature_rden;
            rd_idx_q <= kidx_q;
            if (rd_vld_q) begin
                cap_vld_q  <= 1'b1;
                cap_idx_q  <= rd_idx_q;
                cap_data_q <= in_feature_q;
                if (cap_vld_q && !use_cap_s) begin
                    bk_vld_q  <= 1'b1;
                    bk_idx_q  <= cap_idx_q;
                    bk_data_q <= cap_data_q;
                end else if (use_bk_s) begin
                    bk_vld_q <= 1'b0;
                end
            end else begin
                cap_vld_q <= cap_vld_q & ~use_cap_s;
                if (use_bk_s) begin
                    bk_vld_q <= 1'b0;
                end
            end
        end
    end

    // Weight file: writable only while idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < KK; i++) begin
                wt_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wt_wren && (state_q == IDLE) && ({1'b0, wt_addr} < (WT_AW + 1)'(KK))) begin
            wt_q[wt_addr] <= wt_data;
        end
    end

endmodule
